// File: rtl/microstate_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// microstate_sequencer_pkg
// Shared control-unit definitions for the microstate sequencer and its
// condition decoder.
//   - Next_State_Address_Select encodings (SEL_*)
//   - microinstruction condition field encodings (COND_*)
//   - well-known microstate addresses (RESET_STATE, FETCH_STATE)
//   - sequencer FSM state type
// ---------------------------------------------------------------------------
package microstate_sequencer_pkg;

    // Next-state address multiplexer select encodings
    localparam logic [1:0] SEL_ENCODER = 2'b00;
    localparam logic [1:0] SEL_FETCH   = 2'b01;
    localparam logic [1:0] SEL_CR      = 2'b10;
    localparam logic [1:0] SEL_INC     = 2'b11;

    // Microinstruction condition field encodings
    localparam logic [2:0] COND_ENCODER = 3'b000;
    localparam logic [2:0] COND_FETCH   = 3'b001;
    localparam logic [2:0] COND_JUMP    = 3'b010;
    localparam logic [2:0] COND_INC     = 3'b011;
    localparam logic [2:0] COND_MOC     = 3'b100;
    localparam logic [2:0] COND_FLAG    = 3'b101;
    localparam logic [2:0] COND_TRAP    = 3'b110;
    localparam logic [2:0] COND_RSVD    = 3'b111;

    // Well-known microstates
    localparam logic [8:0] RESET_STATE = 9'd0;
    localparam logic [8:0] FETCH_STATE = 9'd1;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        SEQ_RESET = 2'b00,
        SEQ_RUN   = 2'b01,
        SEQ_HALT  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/microstate_sequencer_decoder.sv
// ---------------------------------------------------------------------------
// microstate_condition_decoder
// Purely combinational decode of the microinstruction condition field into
// the next-state address select. Tested conditions (MOC, flag, trap) are
// XORed with the invert bit; the unconditional encodings ignore it.
// Ports:
//   i_cond         condition field of the current microinstruction
//   i_inv          condition invert bit
//   i_moc          memory operation complete
//   i_condFlag     branch condition flag
//   i_trapPending  pending trap request
//   o_sel          decoded Next_State_Address_Select
// ---------------------------------------------------------------------------
module microstate_condition_decoder
    import microstate_sequencer_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_inv,
    input  logic       i_moc,
    input  logic       i_condFlag,
    input  logic       i_trapPending,
    output logic [1:0] o_sel
);

    // A failing MOC test selects the control register so the word can loop
    // on itself while memory is busy; success falls through to increment.
    always_comb begin
        o_sel = SEL_FETCH;
        case (i_cond)
            COND_ENCODER: o_sel = SEL_ENCODER;
            COND_FETCH:   o_sel = SEL_FETCH;
            COND_JUMP:    o_sel = SEL_CR;
            COND_INC:     o_sel = SEL_INC;
            COND_MOC:     o_sel = (i_moc ^ i_inv) ? SEL_INC : SEL_CR;
            COND_FLAG:    o_sel = (i_condFlag ^ i_inv) ? SEL_CR : SEL_INC;
            COND_TRAP:    o_sel = (i_trapPending ^ i_inv) ? SEL_CR : SEL_INC;
            default:      o_sel = SEL_FETCH;
        endcase
    end

endmodule

// File: rtl/microstate_sequencer.sv
// ---------------------------------------------------------------------------
// microstate_sequencer
// Sequencing side of the control unit: holds the current microstate
// (Microstore address) and its registered +1, decodes the next-state
// address select and jump target, and registers the address the next-state
// multiplexer returns. Adds reset sequencing, halt/resume, external hold and
// an optional memory-wait timeout.
//
// Optional feature macro: SEQ_MOC_TIMEOUT_EN
//   defined   -> a failing MOC wait lasting MOC_TIMEOUT cycles forces a jump
//                to TRAP_VECTOR and pulses Moc_Timeout
//   undefined -> waits are unbounded, Moc_Timeout is tied low
//
// Ports:
//   Clock, Reset_N                 clock (rising) / async active-low reset
//   Next_State_Address             address returned by the next-state mux
//   Cond, Inv, Halt, CR_Field      current microinstruction fields
//   MOC, Condition_Flag,
//   Trap_Pending                   tested status inputs
//   Hold                           external stall
//   Resume                         one-cycle pulse releasing HALT
//   Microstore_Address             current microstate
//   Incrementer_Register_Address   registered current microstate + 1
//   Control_Register_Address       jump target to the next-state mux
//   Next_State_Address_Select      00 encoder/01 fetch/10 CR/11 incrementer
//   Halted                         high while in HALT
//   Moc_Timeout                    one-cycle timeout pulse
// ---------------------------------------------------------------------------
module microstate_sequencer
    import microstate_sequencer_pkg::*;
#(
    parameter int         MOC_TIMEOUT = 64,
    parameter logic [8:0] TRAP_VECTOR = 9'd8
)
(
    input  logic       Clock,
    input  logic       Reset_N,
    input  logic [8:0] Next_State_Address,
    input  logic [2:0] Cond,
    input  logic       Inv,
    input  logic       Halt,
    input  logic [8:0] CR_Field,
    input  logic       MOC,
    input  logic       Condition_Flag,
    input  logic       Trap_Pending,
    input  logic       Hold,
    input  logic       Resume,
    output logic [8:0] Microstore_Address,
    output logic [8:0] Incrementer_Register_Address,
    output logic [8:0] Control_Register_Address,
    output logic [1:0] Next_State_Address_Select,
    output logic       Halted,
    output logic       Moc_Timeout
);

    seq_state_t r_state;
    logic [8:0] r_msAddr;
    logic [8:0] r_incAddr;
    logic       r_halted;
    logic [1:0] w_decSel;
    logic [1:0] w_sel;
    logic       w_timeout;

    microstate_condition_decoder u_decoder (
        .i_cond        (Cond),
        .i_inv         (Inv),
        .i_moc         (MOC),
        .i_condFlag    (Condition_Flag),
        .i_trapPending (Trap_Pending),
        .o_sel         (w_decSel)
    );

`ifdef SEQ_MOC_TIMEOUT_EN
    localparam int         CNT_W    = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    logic [CNT_W-1:0] r_mocCount;
    logic             w_waitCond;

    assign w_waitCond = (Cond == COND_MOC) && !(MOC ^ Inv);
    assign w_timeout  = (r_state == SEQ_RUN) && w_waitCond && (r_mocCount == CNT_LAST);

    // Counts consecutive failing MOC waits; the timeout edge itself clears
    // the count so the trap handler starts with a fresh budget.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            r_mocCount <= '0;
        end else if (!Hold) begin
            if ((r_state == SEQ_RUN) && w_waitCond && !w_timeout) begin
                r_mocCount <= r_mocCount + 1'b1;
            end else begin
                r_mocCount <= '0;
            end
        end
    end
`else
    logic w_unusedMocTimeout;

    assign w_unusedMocTimeout = (MOC_TIMEOUT != 0);
    assign w_timeout          = 1'b0;
`endif

    // Outside RUN the multiplexer is pointed at the fetch state so that both
    // reset exit and resume land on FETCH_STATE.
    always_comb begin
        w_sel = SEL_FETCH;
        if (r_state == SEQ_RUN) begin
            w_sel = w_timeout ? SEL_CR : w_decSel;
        end
    end

    // Sequencer FSM plus the address registers it owns. Hold freezes
    // everything except the HALT exit, which honours Resume regardless.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state   <= SEQ_RESET;
            r_msAddr  <= RESET_STATE;
            r_incAddr <= RESET_STATE + 9'd1;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                SEQ_RESET: begin
                    if (!Hold) begin
                        r_msAddr  <= Next_State_Address;
                        r_incAddr <= Next_State_Address + 9'd1;
                        r_state   <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (!Hold) begin
                        if (Halt) begin
                            r_state  <= SEQ_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_msAddr  <= Next_State_Address;
                            r_incAddr <= Next_State_Address + 9'd1;
                        end
                    end
                end
                SEQ_HALT: begin
                    if (Resume) begin
                        r_msAddr  <= Next_State_Address;
                        r_incAddr <= Next_State_Address + 9'd1;
                        r_state   <= SEQ_RUN;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SEQ_RESET;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign Microstore_Address           = r_msAddr;
    assign Incrementer_Register_Address = r_incAddr;
    assign Control_Register_Address     = w_timeout ? TRAP_VECTOR : CR_Field;
    assign Next_State_Address_Select    = w_sel;
    assign Halted                       = r_halted;
    assign Moc_Timeout                  = w_timeout;

endmodule

// File: tb/tb_microstate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microstate_sequencer
// Directed bench for microstate_sequencer. The bench plays the role of the
// next-state multiplexer by driving Next_State_Address with the value the
// mux would return; expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_microstate_sequencer;

   logic       Clock;
   logic       Reset_N;
   logic [8:0] Next_State_Address;
   logic [2:0] Cond;
   logic       Inv;
   logic       Halt;
   logic [8:0] CR_Field;
   logic       MOC;
   logic       Condition_Flag;
   logic       Trap_Pending;
   logic       Hold;
   logic       Resume;
   logic [8:0] Microstore_Address;
   logic [8:0] Incrementer_Register_Address;
   logic [8:0] Control_Register_Address;
   logic [1:0] Next_State_Address_Select;
   logic       Halted;
   logic       Moc_Timeout;

   int compareCount;
   int mismatchCount;

   microstate_sequencer #(
      .MOC_TIMEOUT (4),
      .TRAP_VECTOR (9'd8)
   ) dut (
      .Clock                        (Clock),
      .Reset_N                      (Reset_N),
      .Next_State_Address           (Next_State_Address),
      .Cond                         (Cond),
      .Inv                          (Inv),
      .Halt                         (Halt),
      .CR_Field                     (CR_Field),
      .MOC                          (MOC),
      .Condition_Flag               (Condition_Flag),
      .Trap_Pending                 (Trap_Pending),
      .Hold                         (Hold),
      .Resume                       (Resume),
      .Microstore_Address           (Microstore_Address),
      .Incrementer_Register_Address (Incrementer_Register_Address),
      .Control_Register_Address     (Control_Register_Address),
      .Next_State_Address_Select    (Next_State_Address_Select),
      .Halted                       (Halted),
      .Moc_Timeout                  (Moc_Timeout)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives the condition-related microinstruction fields and status inputs
   task automatic applyStimulus(input logic [2:0] cond, input logic inv, input logic moc,
                                input logic flag, input logic trap);
      Cond           = cond;
      Inv            = inv;
      MOC            = moc;
      Condition_Flag = flag;
      Trap_Pending   = trap;
   endtask

   // One rising edge, then back to the falling edge for sampling and driving
   task automatic advanceClock();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Select table: {cond, inv, moc, flag, trap, expected select}
   typedef struct {
      logic [2:0] cond;
      logic       inv;
      logic       moc;
      logic       flag;
      logic       trap;
      logic [1:0] sel;
   } selVector_t;

   selVector_t selTable[11];

   initial begin
      selTable[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      selTable[1]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      selTable[2]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      selTable[3]  = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
      selTable[4]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
      selTable[5]  = '{3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
      selTable[6]  = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
      selTable[7]  = '{3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      selTable[8]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
      selTable[9]  = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
      selTable[10] = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
   end

   // Main directed sequence
   initial begin
      compareCount       = 0;
      mismatchCount      = 0;
      Reset_N            = 1'b1;
      Hold               = 1'b0;
      Halt               = 1'b0;
      Resume             = 1'b0;
      Next_State_Address = 9'd1;
      CR_Field           = 9'd85;
      applyStimulus(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);

      #2 Reset_N = 1'b0;
      @(negedge Clock);
      checkOutput("resetMs", Microstore_Address, 9'd0);
      checkOutput("resetInc", Incrementer_Register_Address, 9'd1);
      checkOutput("resetHalted", {8'd0, Halted}, 9'd0);
      checkOutput("resetSel", {7'd0, Next_State_Address_Select}, 9'd1);
      checkOutput("resetCr", Control_Register_Address, 9'd85);
      checkOutput("resetTimeout", {8'd0, Moc_Timeout}, 9'd0);

      // Reset exit loads the fetch state
      Reset_N = 1'b1;
      advanceClock();
      checkOutput("exitMs", Microstore_Address, 9'd1);
      checkOutput("exitInc", Incrementer_Register_Address, 9'd2);
      checkOutput("exitSel", {7'd0, Next_State_Address_Select}, 9'd3);

      // Select decode while held, so registers must not move
      Hold = 1'b1;
      Next_State_Address = 9'd300;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(selTable[i].cond, selTable[i].inv, selTable[i].moc,
                       selTable[i].flag, selTable[i].trap);
         #1;
         checkOutput($sformatf("sel%0d", i), {7'd0, Next_State_Address_Select}, {7'd0, selTable[i].sel});
      end
      @(negedge Clock);
      checkOutput("holdTableMs", Microstore_Address, 9'd1);
      checkOutput("holdTableInc", Incrementer_Register_Address, 9'd2);
      Hold = 1'b0;

      // MOC wait loop on the current state, mux returns the CR field
      applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      CR_Field           = 9'd1;
      Next_State_Address = 9'd1;
`ifndef SEQ_MOC_TIMEOUT_EN
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("waitSel%0d", i), {7'd0, Next_State_Address_Select}, 9'd2);
         checkOutput($sformatf("waitMs%0d", i), Microstore_Address, 9'd1);
         checkOutput($sformatf("waitTimeout%0d", i), {8'd0, Moc_Timeout}, 9'd0);
         advanceClock();
      end
      MOC = 1'b1;
      Next_State_Address = 9'd2;
      #1;
      checkOutput("mocDoneSel", {7'd0, Next_State_Address_Select}, 9'd3);
      advanceClock();
      checkOutput("mocDoneMs", Microstore_Address, 9'd2);
      checkOutput("mocDoneInc", Incrementer_Register_Address, 9'd3);
`else
      // Counter starts at 0; fourth wait cycle is the timeout cycle
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("waitSel%0d", i), {7'd0, Next_State_Address_Select}, 9'd2);
         checkOutput($sformatf("waitTimeout%0d", i), {8'd0, Moc_Timeout}, 9'd0);
         checkOutput($sformatf("waitCr%0d", i), Control_Register_Address, 9'd1);
         advanceClock();
      end
      #1;
      checkOutput("toPulse", {8'd0, Moc_Timeout}, 9'd1);
      checkOutput("toSel", {7'd0, Next_State_Address_Select}, 9'd2);
      checkOutput("toCr", Control_Register_Address, 9'd8);
      Next_State_Address = 9'd8;
      advanceClock();
      checkOutput("toMs", Microstore_Address, 9'd8);
      checkOutput("toCleared", {8'd0, Moc_Timeout}, 9'd0);
`endif

      // Incrementer wraps from 511 to 0
      applyStimulus(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
      Next_State_Address = 9'd511;
      advanceClock();
      checkOutput("wrapMs", Microstore_Address, 9'd511);
      checkOutput("wrapInc", Incrementer_Register_Address, 9'd0);
      Next_State_Address = 9'd0;
      advanceClock();
      checkOutput("afterWrapMs", Microstore_Address, 9'd0);
      checkOutput("afterWrapInc", Incrementer_Register_Address, 9'd1);

      // Halt at state 20, then resume to fetch
      Next_State_Address = 9'd20;
      advanceClock();
      checkOutput("preHaltMs", Microstore_Address, 9'd20);
      Halt = 1'b1;
      Next_State_Address = 9'd99;
      advanceClock();
      Halt = 1'b0;
      checkOutput("haltedFlag", {8'd0, Halted}, 9'd1);
      checkOutput("haltSel", {7'd0, Next_State_Address_Select}, 9'd1);
      Next_State_Address = 9'd1;
      for (int i = 0; i < 10; i++) begin
         advanceClock();
         checkOutput($sformatf("haltMs%0d", i), Microstore_Address, 9'd20);
      end
      checkOutput("haltInc", Incrementer_Register_Address, 9'd21);
      Resume = 1'b1;
      advanceClock();
      Resume = 1'b0;
      checkOutput("resumeMs", Microstore_Address, 9'd1);
      checkOutput("resumeInc", Incrementer_Register_Address, 9'd2);
      checkOutput("resumeHalted", {8'd0, Halted}, 9'd0);

      // External hold mid-run
      Next_State_Address = 9'd5;
      advanceClock();
      Hold = 1'b1;
      Next_State_Address = 9'd77;
      for (int i = 0; i < 3; i++) begin
         advanceClock();
         checkOutput($sformatf("holdMs%0d", i), Microstore_Address, 9'd5);
         checkOutput($sformatf("holdInc%0d", i), Incrementer_Register_Address, 9'd6);
      end
      Hold = 1'b0;

      // Asynchronous reset while halted
      Halt = 1'b1;
      advanceClock();
      Halt = 1'b0;
      checkOutput("preResetHalted", {8'd0, Halted}, 9'd1);
      #2 Reset_N = 1'b0;
      #1;
      checkOutput("asyncMs", Microstore_Address, 9'd0);
      checkOutput("asyncInc", Incrementer_Register_Address, 9'd1);
      checkOutput("asyncHalted", {8'd0, Halted}, 9'd0);
      checkOutput("asyncSel", {7'd0, Next_State_Address_Select}, 9'd1);
      @(negedge Clock);
      Reset_N = 1'b1;

      // Hold keeps the sequencer in reset state, then release
      Hold = 1'b1;
      Next_State_Address = 9'd1;
      advanceClock();
      checkOutput("resetHoldMs", Microstore_Address, 9'd0);
      Hold = 1'b0;
      advanceClock();
      checkOutput("reExitMs", Microstore_Address, 9'd1);
      checkOutput("reExitInc", Incrementer_Register_Address, 9'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/microstate_sequencer.md
Name: microstate_sequencer

Overview:
- Drives the sequencing side of the control unit.
- Holds the current microstate register that addresses the Microstore, and the incrementer register (current + 1).
- Evaluates the current microinstruction's condition field to produce the 2-bit Next_State_Address_Select and the jump target consumed by the next-state address multiplexer.
- Registers the address that multiplexer returns, closing the loop.
- Adds reset sequencing, a halt/resume handshake, an external hold, and an optional memory-wait timeout.

Parameters:
MOC_TIMEOUT, 64, cycles a failing MOC test may persist before a timeout trap (optional feature only)
TRAP_VECTOR, 9'd8, microstate forced on MOC timeout

Ports:
Clock  in  1  system clock, rising edge
Reset_N  in  1  asynchronous, active-low reset
Next_State_Address  in  9  address returned by the next-state address multiplexer
Cond  in  3  microinstruction condition field (current word)
Inv  in  1  microinstruction condition invert bit
Halt  in  1  microinstruction halt bit
CR_Field  in  9  microinstruction jump-target field
MOC  in  1  memory operation complete
Condition_Flag  in  1  branch condition from condition evaluator
Trap_Pending  in  1  trap request from trap logic
Hold  in  1  external stall (debug single-step / bus hold)
Resume  in  1  one-cycle pulse releasing HALT
Microstore_Address  out  9  current microstate register
Incrementer_Register_Address  out  9  registered current microstate + 1
Control_Register_Address  out  9  jump target to multiplexer
Next_State_Address_Select  out  2  00 encoder, 01 fetch, 10 control register, 11 incrementer
Halted  out  1  high while FSM is in HALT
Moc_Timeout  out  1  one-cycle timeout pulse (0 without the optional feature)

Behaviour:
- Reset (Reset_N=0, async):
  - Microstore_Address=0, Incrementer_Register_Address=1.
  - FSM=SEQ_RESET, Halted=0, timeout counter=0.
- Combinational outputs in all FSM states:
  - Control_Register_Address=CR_Field, except on a timeout cycle.
  - Moc_Timeout=0, except on a timeout cycle.
- FSM states SEQ_RESET, SEQ_RUN, SEQ_HALT:
  - SEQ_RESET: select=01. First edge with Hold=0 loads Next_State_Address (=1) and goes to SEQ_RUN.
  - SEQ_RUN: select decoded from Cond, as below.
    - Edge with Hold=0 and Halt=0: Microstore_Address<=Next_State_Address; Incrementer_Register_Address<=Next_State_Address+1 (9-bit wrap, 511->0).
    - Edge with Hold=0 and Halt=1: go to SEQ_HALT; both registers hold.
  - SEQ_HALT: Halted=1, select=01, registers frozen.
    - Edge with Resume=1 (Hold ignored): load Next_State_Address (=1), go to SEQ_RUN.
    - Resume in any other state is ignored.
- Cond decode in SEQ_RUN (T denotes the tested signal XOR Inv):
  - 000: 00 (encoder).
  - 001: 01 (fetch).
  - 010: 10 (unconditional jump).
  - 011: 11 (increment).
  - 100: MOC test. T=1 -> 11; T=0 -> 10 (wait loop; CR_Field normally equals the current state).
  - 101: Condition_Flag test. T=1 -> 10; T=0 -> 11.
  - 110: Trap_Pending test. T=1 -> 10; T=0 -> 11.
  - 111: reserved -> 01.
  - Inv is ignored for 000-011 and 111.
- Hold=1: all registers and the counter freeze; outputs remain driven from current values.
- Select is purely combinational from the current state and inputs. Zero-cycle decision, one-cycle register latency to the new Microstore_Address.
- Reset mid-operation (including mid-HALT or mid-wait) returns immediately to the reset values.

Optional Feature:
- Macro SEQ_MOC_TIMEOUT_EN.
- With the macro defined:
  - Counter increments on each non-held SEQ_RUN edge where Cond=100 and T=0.
  - Counter clears on any other non-held edge.
  - When the counter equals MOC_TIMEOUT-1 and the wait condition is still true: Moc_Timeout=1, select=10, Control_Register_Address=TRAP_VECTOR for that cycle; the counter clears on the following edge.
- Without the macro: no counter, Moc_Timeout tied 0, waits are unbounded.

Decomposition:
- Shared control-unit package holds:
  - select encodings (SEL_ENCODER=2'b00, SEL_FETCH=2'b01, SEL_CR=2'b10, SEL_INC=2'b11);
  - Cond encodings 000-111;
  - FETCH_STATE=9'd1 and RESET_STATE=9'd0;
  - FSM state encodings.
- One natural sub-module: microstate_condition_decoder (combinational Cond/Inv/flags -> select).
- The FSM, registers and timeout counter stay in the top.

Test Plan:
- Reset release with Next_State_Address=1 -> after first edge Microstore_Address=1, Incrementer_Register_Address=2, select follows Cond.
- Cond=100, Inv=0, MOC=0 for 5 cycles, then MOC=1 -> select=10 for 5 cycles, then 11; address advances to Incrementer value.
- Current state 511 with Cond=011 -> Next_State_Address=511 loaded; Incrementer_Register_Address=0.
- Halt=1 at state 20 -> Halted=1, Microstore_Address stays 20 for 10 cycles; Resume pulse -> Microstore_Address=1, Halted=0.
- Hold=1 for 3 cycles mid-run -> Microstore_Address and Incrementer_Register_Address unchanged; Reset_N low mid-HALT -> Microstore_Address=0 asynchronously.
- With SEQ_MOC_TIMEOUT_EN and MOC_TIMEOUT=4, MOC stuck 0 -> Moc_Timeout pulses on the 4th wait cycle, select=10, Control_Register_Address=8, next Microstore_Address=8.
